// File: rtl/obi_wishbone_bridge.sv
// OBI responder that replays each granted access as one classic Wishbone master cycle.
// Optional Wishbone wait timeout is built only when OBI_WB_TIMEOUT_EN is defined.
module obi_wishbone_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk_core,
   input  logic        rst_core,
   input  logic        obi_req_i,
   output logic        obi_gnt_o,
   input  logic [31:0] obi_addr_i,
   input  logic        obi_we_i,
   input  logic [3:0]  obi_be_i,
   input  logic [31:0] obi_wdata_i,
   output logic        obi_rvalid_o,
   output logic [31:0] obi_rdata_o,
   output logic        obi_err_o,
   output logic        core_cyc,
   output logic        core_stb,
   output logic        core_we,
   output logic [3:0]  core_sel,
   output logic [31:0] core_addr,
   output logic [31:0] core_data_out,
   input  logic [31:0] core_data_in,
   input  logic        core_ack
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t      state;
   logic        cyc_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        rvalid_q;
   logic        timed_out;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 2..65535");
   end

   // A grant in RESP overlaps the response beat, giving one access every two cycles.
   assign obi_gnt_o = obi_req_i & ((state == IDLE) | (state == RESP));

`ifdef OBI_WB_TIMEOUT_EN
   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt;
   logic        err_q;

   // Ack in the final allowed cycle still wins over the timeout.
   assign timed_out = (state == BUS) & ~core_ack & (wait_cnt == LAST_WAIT);

   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (obi_gnt_o)
            wait_cnt <= '0;
         else if (state == BUS && !core_ack)
            wait_cnt <= wait_cnt + 16'd1;

         if (state == BUS && core_ack)
            err_q <= 1'b0;
         else if (timed_out)
            err_q <= 1'b1;
      end
   end

   assign obi_err_o = err_q;
`else
   assign timed_out = 1'b0;
   assign obi_err_o = 1'b0;
`endif

   // NOTE: the async reset clears cyc_q directly, so cyc/stb fall without waiting for an edge.
   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         state    <= IDLE;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;

         if (obi_gnt_o) begin
            addr_q  <= obi_addr_i & 32'hFFFF_FFFC;
            we_q    <= obi_we_i;
            be_q    <= obi_be_i;
            wdata_q <= obi_wdata_i;
         end

         case (state)
            IDLE: begin
               if (obi_req_i) begin
                  state <= BUS;
                  cyc_q <= 1'b1;
               end
            end
            BUS: begin
               if (core_ack) begin
                  rdata_q  <= we_q ? 32'h0 : core_data_in;
                  state    <= RESP;
                  cyc_q    <= 1'b0;
                  rvalid_q <= 1'b1;
               end else if (timed_out) begin
                  rdata_q  <= ERR_RDATA;
                  state    <= RESP;
                  cyc_q    <= 1'b0;
                  rvalid_q <= 1'b1;
               end
            end
            RESP: begin
               if (obi_req_i) begin
                  state <= BUS;
                  cyc_q <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cyc_q <= 1'b0;
            end
         endcase
      end
   end

   assign core_cyc      = cyc_q;
   assign core_stb      = cyc_q;
   assign core_we       = we_q;
   assign core_sel      = be_q;
   assign core_addr     = addr_q;
   assign core_data_out = wdata_q;
   assign obi_rvalid_o  = rvalid_q;
   assign obi_rdata_o   = rdata_q;

endmodule

// File: tb/tb_obi_wishbone_bridge.sv
// Directed bench for obi_wishbone_bridge: vector table plus hand-written corner sequences.
module tb_obi_wishbone_bridge;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] slave_data;
      logic [31:0] exp_addr;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk_core = 1'b0;
   logic        rst_core = 1'b1;
   logic        obi_req_i = 1'b0;
   logic        obi_gnt_o;
   logic [31:0] obi_addr_i = '0;
   logic        obi_we_i = 1'b0;
   logic [3:0]  obi_be_i = '0;
   logic [31:0] obi_wdata_i = '0;
   logic        obi_rvalid_o;
   logic [31:0] obi_rdata_o;
   logic        obi_err_o;
   logic        core_cyc;
   logic        core_stb;
   logic        core_we;
   logic [3:0]  core_sel;
   logic [31:0] core_addr;
   logic [31:0] core_data_out;
   logic [31:0] core_data_in = 32'h7777_7777;
   logic        core_ack = 1'b0;

   int total = 0;
   int bad   = 0;

   obi_wishbone_bridge #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .clk_core(clk_core), .rst_core(rst_core),
      .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
      .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
      .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
      .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel),
      .core_addr(core_addr), .core_data_out(core_data_out),
      .core_data_in(core_data_in), .core_ack(core_ack)
   );

   always #5 clk_core = ~clk_core;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_core);
      #1;
   endtask

   // One access from an idle bridge; slave acks after v.waits wait states.
   task automatic do_access(input vec_t v);
      obi_req_i   = 1'b1;
      obi_addr_i  = v.addr;
      obi_we_i    = v.we;
      obi_be_i    = v.be;
      obi_wdata_i = v.wdata;
      #1;
      check("gnt_idle", 32'(obi_gnt_o), 32'd1);
      next_cycle();
      obi_req_i   = 1'b0;
      obi_wdata_i = 32'h0;
      obi_addr_i  = 32'h0;
      for (int w = 0; w <= v.waits; w++) begin
         check("bus_cyc", 32'(core_cyc), 32'd1);
         check("bus_stb", 32'(core_stb), 32'd1);
         check("bus_addr", core_addr, v.exp_addr);
         check("bus_we", 32'(core_we), 32'(v.we));
         check("bus_sel", 32'(core_sel), 32'(v.be));
         check("bus_wdata", core_data_out, v.wdata);
         check("bus_no_rvalid", 32'(obi_rvalid_o), 32'd0);
         if (w == v.waits) begin
            core_ack     = 1'b1;
            core_data_in = v.slave_data;
         end
         next_cycle();
         core_ack     = 1'b0;
         core_data_in = 32'h7777_7777;
      end
      check("resp_rvalid", 32'(obi_rvalid_o), 32'd1);
      check("resp_rdata", obi_rdata_o, v.exp_rdata);
      check("resp_err", 32'(obi_err_o), 32'd0);
      check("resp_cyc_low", 32'(core_cyc), 32'd0);
      next_cycle();
      check("idle_rvalid", 32'(obi_rvalid_o), 32'd0);
      check("idle_rdata_hold", obi_rdata_o, v.exp_rdata);
   endtask

   vec_t        vecs[5];
   logic [31:0] b2b_data[4];

   initial begin
      vecs[0] = '{32'h0000_0102, 1'b0, 4'hF,    32'h0,         0, 32'h1234_5678, 32'h0000_0100, 32'h1234_5678};
      vecs[1] = '{32'h0000_0040, 1'b1, 4'b0011, 32'hAABB_CCDD, 3, 32'h5555_5555, 32'h0000_0040, 32'h0};
      vecs[2] = '{32'hFFFF_FFFF, 1'b0, 4'b1000, 32'h0,         1, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'hCAFE_F00D};
      vecs[3] = '{32'h8000_0007, 1'b1, 4'b1100, 32'h0102_0304, 0, 32'h6666_6666, 32'h8000_0004, 32'h0};
      vecs[4] = '{32'h0000_0203, 1'b0, 4'b0001, 32'h0,         2, 32'h0BAD_C0DE, 32'h0000_0200, 32'h0BAD_C0DE};
      b2b_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

      // Reset state
      #12;
      check("rst_cyc", 32'(core_cyc), 32'd0);
      check("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
      check("rst_rdata", obi_rdata_o, 32'd0);
      check("rst_addr", core_addr, 32'd0);
      check("rst_gnt_low", 32'(obi_gnt_o), 32'd0);
      obi_req_i = 1'b1;
      #1;
      check("rst_gnt_follows_req", 32'(obi_gnt_o), 32'd1);
      obi_req_i = 1'b0;
      @(negedge clk_core);
      rst_core = 1'b0;
      next_cycle();

      for (int i = 0; i < 5; i++) do_access(vecs[i]);

      // Back-to-back reads with req held high
      for (int k = 0; k < 4; k++) begin
         obi_req_i  = 1'b1;
         obi_we_i   = 1'b0;
         obi_be_i   = 4'hF;
         obi_addr_i = 32'h0000_1000 + 32'(4 * k);
         #1;
         check("b2b_gnt", 32'(obi_gnt_o), 32'd1);
         if (k > 0) begin
            check("b2b_rvalid", 32'(obi_rvalid_o), 32'd1);
            check("b2b_rdata", obi_rdata_o, b2b_data[k-1]);
         end
         next_cycle();
         check("b2b_bus_gnt_low", 32'(obi_gnt_o), 32'd0);
         check("b2b_cyc", 32'(core_cyc), 32'd1);
         check("b2b_addr", core_addr, 32'h0000_1000 + 32'(4 * k));
         core_ack     = 1'b1;
         core_data_in = b2b_data[k];
         next_cycle();
         core_ack     = 1'b0;
         core_data_in = 32'h7777_7777;
      end
      obi_req_i = 1'b0;
      check("b2b_last_rvalid", 32'(obi_rvalid_o), 32'd1);
      check("b2b_last_rdata", obi_rdata_o, b2b_data[3]);
      check("b2b_last_cyc", 32'(core_cyc), 32'd0);
      next_cycle();
      check("b2b_idle_rvalid", 32'(obi_rvalid_o), 32'd0);

      // Spurious ack in IDLE
      core_ack     = 1'b1;
      core_data_in = 32'h9999_9999;
      next_cycle();
      core_ack     = 1'b0;
      check("spur_rvalid", 32'(obi_rvalid_o), 32'd0);
      check("spur_cyc", 32'(core_cyc), 32'd0);
      check("spur_rdata_hold", obi_rdata_o, b2b_data[3]);
      next_cycle();
      check("spur_rvalid_late", 32'(obi_rvalid_o), 32'd0);
      obi_req_i = 1'b1;
      #1;
      check("spur_still_idle_gnt", 32'(obi_gnt_o), 32'd1);
      obi_req_i = 1'b0;
      #1;

      // Reset mid-BUS
      obi_req_i  = 1'b1;
      obi_addr_i = 32'h0000_0500;
      obi_we_i   = 1'b0;
      next_cycle();
      obi_req_i = 1'b0;
      check("midrst_cyc_before", 32'(core_cyc), 32'd1);
      #2;
      rst_core = 1'b1;
      #1;
      check("midrst_cyc_async", 32'(core_cyc), 32'd0);
      check("midrst_stb_async", 32'(core_stb), 32'd0);
      core_ack     = 1'b1;
      core_data_in = 32'h5A5A_5A5A;
      @(negedge clk_core);
      core_ack = 1'b0;
      rst_core = 1'b0;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         check("midrst_no_rvalid", 32'(obi_rvalid_o), 32'd0);
         check("midrst_no_cyc", 32'(core_cyc), 32'd0);
      end
      do_access('{32'h0000_0604, 1'b0, 4'hF, 32'h0, 0, 32'h00C0_FFEE, 32'h0000_0604, 32'h00C0_FFEE});

`ifdef OBI_WB_TIMEOUT_EN
      // Slave never acks: eight BUS cycles then an error response
      obi_req_i  = 1'b1;
      obi_addr_i = 32'h0000_0700;
      next_cycle();
      obi_req_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
         check("to_cyc_held", 32'(core_cyc), 32'd1);
         next_cycle();
      end
      check("to_cyc_dropped", 32'(core_cyc), 32'd0);
      check("to_rvalid", 32'(obi_rvalid_o), 32'd1);
      check("to_err", 32'(obi_err_o), 32'd1);
      check("to_rdata", obi_rdata_o, 32'hDEAD_BEEF);
      next_cycle();
      check("to_idle_rvalid", 32'(obi_rvalid_o), 32'd0);
      // Ack in the eighth cycle wins
      do_access('{32'h0000_0708, 1'b0, 4'hF, 32'h0, 7, 32'h1357_9BDF, 32'h0000_0708, 32'h1357_9BDF});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
